// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions and default sizes.
package alu_pkg;
  localparam int FLG_N      = 3;
  localparam int FLG_Z      = 2;
  localparam int FLG_C      = 1;
  localparam int FLG_V      = 0;
  localparam int FLAG_W     = 4;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                   input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction
endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous first-word-fall-through FIFO. Occupancy is counted explicitly so that
// full and empty stay distinct even though both pointers wrap modulo DEPTH.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int W     = DATA_W_DEF + FLAG_W,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [LVL_W-1:0] level_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; contents are only observable while level is nonzero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results with valid/ready handshakes and keeps committed
// status (last retired flags, sticky overflow, retired-result count).
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic              in_cout,
  input  logic              in_negative,
  input  logic              in_zero,
  input  logic              in_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [FLAG_W-1:0] out_flags,
  output logic [FLAG_W-1:0] last_flags,
  output logic              sticky_ovf,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [LVL_W-1:0]  level
);

  localparam int ENT_W = DATA_W + FLAG_W;

  logic             push, pop;
  logic [ENT_W-1:0] head;
  logic [FLAG_W-1:0] last_flags_q, last_flags_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Ready looks only at stored occupancy, so a full FIFO refuses a push even when it pops.
  assign in_ready  = (level != LVL_W'(DEPTH)) & ~rst;
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  alu_res_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_y, pack_flags(in_negative, in_zero, in_cout, in_overflow)}),
    .rdata_o (head),
    .level_o (level)
  );

  assign out_y     = head[ENT_W-1:FLAG_W];
  assign out_flags = head[FLAG_W-1:0];

  always_comb begin
    last_flags_d = last_flags_q;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (pop) begin
      last_flags_d = out_flags;
      cnt_d        = cnt_q + CNT_W'(1);
      // An overflowing retire in the same cycle as a clear keeps the bit set.
      if (out_flags[FLG_V]) sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_flags_q <= '0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      last_flags_q <= last_flags_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign last_flags  = last_flags_q;
  assign sticky_ovf  = sticky_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected entries are queued on accepted pushes
// and compared against the head at every negative clock edge.
module tb_alu_result_stage;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic        in_cout, in_negative, in_zero, in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_flags;
  logic [3:0]  last_flags;
  logic        sticky_ovf;
  logic        clr_sticky;
  logic [3:0]  retired_cnt;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  logic [35:0] sb[$];
  logic        mdl_ok = 1'b0;
  logic [3:0]  m_last;
  logic        m_sticky;
  logic [3:0]  m_cnt;

  always #5 clk = ~clk;

  alu_result_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_y        (in_y),
    .in_cout     (in_cout),
    .in_negative (in_negative),
    .in_zero     (in_zero),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_flags   (out_flags),
    .last_flags  (last_flags),
    .sticky_ovf  (sticky_ovf),
    .clr_sticky  (clr_sticky),
    .retired_cnt (retired_cnt),
    .level       (level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state advances at negedge, ahead of the posedge the DUT updates on.
  always @(negedge clk) begin
    logic        m_push, m_pop;
    logic [35:0] ent;
    if (mdl_ok) begin
      chk("in_ready",   32'(in_ready),   32'((sb.size() != DEPTH) && !rst));
      chk("out_valid",  32'(out_valid),  32'(sb.size() != 0));
      chk("level",      32'(level),      32'(sb.size()));
      chk("last_flags", 32'(last_flags), 32'(m_last));
      chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
      chk("retired",    32'(retired_cnt), 32'(m_cnt));
      if (sb.size() != 0) begin
        chk("out_y",     out_y,            sb[0][35:4]);
        chk("out_flags", 32'(out_flags),   32'(sb[0][3:0]));
      end
    end
    if (rst) begin
      sb.delete();
      m_last   = 4'h0;
      m_sticky = 1'b0;
      m_cnt    = 4'h0;
      mdl_ok   = 1'b1;
    end else if (mdl_ok) begin
      m_push = in_valid && (sb.size() != DEPTH);
      m_pop  = out_ready && (sb.size() != 0);
      if (clr_sticky) m_sticky = 1'b0;
      if (m_pop) begin
        ent    = sb.pop_front();
        m_last = ent[3:0];
        m_cnt  = m_cnt + 4'd1;
        if (ent[0]) m_sticky = 1'b1;
      end
      if (m_push) sb.push_back({in_y, in_negative, in_zero, in_cout, in_overflow});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] y, input logic [3:0] nzcv);
    in_y        = y;
    in_negative = nzcv[3];
    in_zero     = nzcv[2];
    in_cout     = nzcv[1];
    in_overflow = nzcv[0];
  endtask

  task automatic drain();
    int n = 0;
    while (level != 3'd0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(level), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; clr_sticky = 1'b0;
    set_in(32'h1234_5678, 4'hF);

    // Reset held two cycles with in_valid asserted
    tick(); tick();
    chk("rst_in_ready",  32'(in_ready),    0);
    chk("rst_out_valid", 32'(out_valid),   0);
    chk("rst_level",     32'(level),       0);
    chk("rst_retired",   32'(retired_cnt), 0);
    chk("rst_last",      32'(last_flags),  0);
    rst = 1'b0; in_valid = 1'b0;

    // Single pass, C only
    out_ready = 1'b1; in_valid = 1'b1; set_in(32'h0000_00FF, 4'b0010);
    tick(); in_valid = 1'b0;
    chk("sp_out_valid", 32'(out_valid), 1);
    chk("sp_out_y",     out_y,          32'h0000_00FF);
    chk("sp_out_flags", 32'(out_flags), 32'h2);
    tick();
    chk("sp_retired",   32'(retired_cnt), 1);
    chk("sp_last",      32'(last_flags),  32'h2);
    chk("sp_level",     32'(level),       0);

    // Fill under backpressure; fifth push must be held
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; set_in(32'(i), 4'(i));
      tick();
    end
    set_in(32'd5, 4'd5);
    tick(); tick();
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_level",    32'(level),    4);
    chk("full_head",     out_y,         1);

    // Full with simultaneous pop: pop taken, push refused this cycle
    out_ready = 1'b1;
    tick();
    chk("fp_level",    32'(level),    3);
    chk("fp_head",     out_y,         2);
    chk("fp_in_ready", 32'(in_ready), 1);
    tick(); in_valid = 1'b0;
    chk("fp_level2",   32'(level),    3);
    drain();
    chk("fill_retired", 32'(retired_cnt), 6);

    // Sticky overflow: set-wins-over-clear, then clear with no pop
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("sticky_cleared", 32'(sticky_ovf), 0);
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(32'hAAAA_0001, 4'b0001); tick();
    set_in(32'hBBBB_0002, 4'b1001); tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("sticky_set", 32'(sticky_ovf), 1);
    clr_sticky = 1'b1;
    tick();
    chk("sticky_set_wins", 32'(sticky_ovf), 1);
    out_ready = 1'b0;
    tick(); clr_sticky = 1'b0;
    chk("sticky_clr", 32'(sticky_ovf), 0);
    chk("sticky_last", 32'(last_flags), 32'h9);

    // Counter wrap: 17 retires from reset on a 4-bit counter
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; set_in($urandom, 4'($urandom_range(0, 15)));
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("wrap_retired", 32'(retired_cnt), 1);

    // Reset with two entries buffered discards them without retiring
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(32'hC0DE_0001, 4'b0001); tick();
    set_in(32'hC0DE_0002, 4'b0100); tick();
    in_valid = 1'b0;
    chk("mid_level", 32'(level), 2);
    out_ready = 1'b1; rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mid_rst_level",     32'(level),       0);
    chk("mid_rst_out_valid", 32'(out_valid),   0);
    chk("mid_rst_retired",   32'(retired_cnt), 0);
    tick(); tick();
    chk("post_rst_retired",  32'(retired_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
